// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops bytes from the sample FIFO and sends them as 8N1 UART frames, LSB first
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] bytes_sent
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic [2:0]       bit_idx, bit_nx;
    logic [7:0]       shift, shift_nx;
    logic             tick, counting;
    logic             rd_nx, tx_nx, busy_nx, done_nx;

    assign tick     = (timer == LAST);
    assign counting = (state == START) || (state == DATA) || (state == STOP);

    // State register; reset abandons any partial frame immediately
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; fifo_empty is only looked at in IDLE, so its stale window after a pop is never seen
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) state_nx = READ;
            READ:    state_nx = WAIT;
            WAIT:    state_nx = START;
            START:   if (tick) state_nx = DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_nx = STOP;
            STOP:    if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of bit timer, bit index and shift register
    always_comb begin
        timer_nx = (!counting || tick || state_nx != state) ? '0 : timer + 1'b1;
        shift_nx = (state == WAIT) ? fifo_data : (state == DATA && tick) ? {1'b0, shift[7:1]} : shift;
        bit_nx   = (state == WAIT) ? 3'd0 : (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
    end

    // Output values for the coming cycle, derived from next state so the outputs can be registered
    always_comb begin
        rd_nx   = (state_nx == READ);
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == STOP) && (timer_nx == LAST);
        tx_nx   = (state_nx == START) ? 1'b0 : (state_nx == DATA) ? shift_nx[0] : 1'b1;
    end

    // Datapath and registered outputs; the frame counter steps on the edge that ends the stop bit
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            timer      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            bytes_sent <= '0;
        end else begin
            timer      <= timer_nx;
            bit_idx    <= bit_nx;
            shift      <= shift_nx;
            fifo_rd_en <= rd_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            tx_done    <= done_nx;
            if (state == STOP && tick) bytes_sent <= bytes_sent + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: directed checks of the FIFO-to-UART drain against a behavioural FIFO
module tb_fifo_uart_drain;
    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
    } vec_t;

    logic        sys_clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en, tx, busy, tx_done;
    logic [15:0] bytes_sent;
    logic        enable2 = 1'b0;
    logic        rd2, tx2, busy2, done2;
    logic [3:0]  bs2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [0:63];
    int         wp = 0;
    int         rp = 0;
    logic       prev_rd = 1'b0;

    fifo_uart_drain #(.CLKS_PER_BIT(N), .CNT_W(16)) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .tx_done(tx_done), .bytes_sent(bytes_sent)
    );

    fifo_uart_drain #(.CLKS_PER_BIT(N), .CNT_W(4)) dut2 (
        .sys_clock(sys_clock), .reset(reset), .enable(enable2), .fifo_empty(1'b0),
        .fifo_data(8'h3C), .fifo_rd_en(rd2), .tx(tx2), .busy(busy2),
        .tx_done(done2), .bytes_sent(bs2)
    );

    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cyc <= cyc + 1;

    assign fifo_empty = (rp == wp);

    always @(posedge sys_clock) begin
        if (fifo_rd_en) fifo_data <= mem[rp % 64];
        prev_rd <= fifo_rd_en;
        if (prev_rd && !fifo_rd_en) rp <= rp + 1;
    end

    always @(negedge sys_clock) begin
        if (reset && fifo_rd_en) begin
            checks++;
            if (fifo_empty) begin
                errors++;
                $display("FAIL rd_on_empty: read pulse at cycle %0d with fifo_empty=1, required empty=0", cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp % 64] = b;
        wp++;
    endtask

    task automatic watch(input int n, output int rd_cnt, output int low_cnt);
        rd_cnt = 0;
        low_cnt = 0;
        repeat (n) begin
            @(negedge sys_clock);
            if (fifo_rd_en) rd_cnt++;
            if (!tx) low_cnt++;
        end
    endtask

    task automatic get_frame(input int drop, output logic [7:0] b, output int rc);
        int n = 0;
        b = 8'h00;
        rc = -1;
        while (fifo_rd_en !== 1'b1 && n < 200) begin
            @(negedge sys_clock);
            n++;
        end
        if (fifo_rd_en !== 1'b1) begin
            chk("frame_timeout", 32'd0, 32'd1);
            return;
        end
        rc = cyc;
        repeat (3) @(negedge sys_clock);
        chk("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (N) @(negedge sys_clock);
            b[i] = tx;
            if (i == drop) enable = 1'b0;
        end
        repeat (N) @(negedge sys_clock);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge sys_clock);
        chk("tx_done", {31'd0, tx_done}, 32'd1);
    endtask

    initial begin
        vec_t       vt [18];
        logic [3:0] trace [0:47];
        logic [7:0] b;
        logic [7:0] burst [3];
        int         rc, prev_rc, rd_cnt, low_cnt, n;

        vt = '{'{0, 4'b0100}, '{1, 4'b1110}, '{2, 4'b0110}, '{3, 4'b0010}, '{4, 4'b0010},
               '{7, 4'b0110}, '{11, 4'b0010}, '{15, 4'b0110}, '{19, 4'b0010}, '{23, 4'b0010},
               '{27, 4'b0110}, '{31, 4'b0010}, '{35, 4'b0110}, '{38, 4'b0110}, '{39, 4'b0110},
               '{41, 4'b0110}, '{42, 4'b0111}, '{43, 4'b0100}};
        burst = '{8'h01, 8'h80, 8'hFF};

        repeat (3) @(negedge sys_clock);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge sys_clock);

        push(8'hA5);
        @(negedge sys_clock);
        enable = 1'b1;
        trace[0] = {fifo_rd_en, tx, busy, tx_done};
        for (int k = 1; k < 48; k++) begin
            @(negedge sys_clock);
            trace[k] = {fifo_rd_en, tx, busy, tx_done};
        end
        for (int v = 0; v < 18; v++)
            chk($sformatf("single_c%0d_rd_tx_busy_done", vt[v].cyc), {28'd0, trace[vt[v].cyc]}, {28'd0, vt[v].exp});
        rd_cnt = 0;
        for (int k = 0; k < 48; k++) if (trace[k][3]) rd_cnt++;
        chk("single_rd_pulses", rd_cnt, 1);
        chk("single_bytes_sent", {16'd0, bytes_sent}, 32'd1);
        enable = 1'b0;

        push(8'h00);
        @(negedge sys_clock);
        enable = 1'b1;
        n = 0;
        while (fifo_rd_en !== 1'b1 && n < 20) begin
            @(negedge sys_clock);
            n++;
        end
        repeat (12) @(negedge sys_clock);
        chk("pre_reset_tx", {31'd0, tx}, 32'd0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("midrst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        enable = 1'b0;
        @(negedge sys_clock);
        reset = 1'b1;
        repeat (3) @(negedge sys_clock);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        push(8'h01);
        push(8'h80);
        push(8'hFF);
        enable = 1'b1;
        prev_rc = -1;
        for (int f = 0; f < 3; f++) begin
            get_frame(-1, b, rc);
            chk($sformatf("burst_byte%0d", f), {24'd0, b}, {24'd0, burst[f]});
            if (f > 0) chk($sformatf("burst_period%0d", f), rc - prev_rc, 43);
            prev_rc = rc;
        end
        watch(60, rd_cnt, low_cnt);
        chk("burst_extra_rd", rd_cnt, 0);
        chk("burst_bytes_sent", {16'd0, bytes_sent}, 32'd3);
        chk("burst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("burst_idle", {31'd0, busy}, 32'd0);

        watch(100, rd_cnt, low_cnt);
        chk("empty_no_rd", rd_cnt, 0);
        chk("empty_tx_high", low_cnt, 0);

        push(8'h5A);
        push(8'hC3);
        get_frame(2, b, rc);
        chk("gate_byte1", {24'd0, b}, 32'h5A);
        watch(100, rd_cnt, low_cnt);
        chk("gate_no_rd", rd_cnt, 0);
        chk("gate_idle", {31'd0, busy}, 32'd0);
        chk("gate_bytes_sent", {16'd0, bytes_sent}, 32'd4);
        enable = 1'b1;
        get_frame(-1, b, rc);
        chk("gate_byte2", {24'd0, b}, 32'hC3);
        @(negedge sys_clock);
        chk("gate_bytes_sent2", {16'd0, bytes_sent}, 32'd5);

        for (int i = 0; i < 15; i++) push(8'(i));
        for (int i = 0; i < 15; i++) begin
            get_frame(-1, b, rc);
            chk($sformatf("drain_byte%0d", i), {24'd0, b}, i);
        end
        watch(100, rd_cnt, low_cnt);
        chk("drain_no_extra_rd", rd_cnt, 0);
        chk("drain_bytes_sent", {16'd0, bytes_sent}, 32'd20);
        enable = 1'b0;

        enable2 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            n = 0;
            while (done2 !== 1'b1 && n < 100) begin
                @(negedge sys_clock);
                n++;
            end
            if (done2 !== 1'b1) chk("wrap_timeout", 32'd0, 32'd1);
            @(negedge sys_clock);
            chk($sformatf("wrap_count%0d", k), {28'd0, bs2}, (k + 1) % 16);
        end
        enable2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_uart_drain.md
Name: fifo_uart_drain

Overview:
- Downstream consumer of the 16-entry byte FIFO. Runs on the same clock.
- Pops one byte at a time from the FIFO and serialises it on a UART TX line, 8N1, LSB first.
- Feeds the host link that carries vibration samples off-board.
- Owns the FIFO read handshake, so the FIFO's read_en is driven only by this block.

Parameters:
- CLKS_PER_BIT, 868, sys_clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- CNT_W, 16, width of the bit-timer and of bytes_sent.

Ports:
- sys_clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = drain FIFO; 0 = finish the current frame, then hold in IDLE.
- fifo_empty  in  1  FIFO isEmpty.
- fifo_data  in  8  FIFO d_out; registered in the FIFO, valid the cycle after a read pulse.
- fifo_rd_en  out  1  FIFO read_en; single-cycle pulse.
- tx  out  1  UART serial output, idle high, registered.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse in the last cycle of the stop bit.
- bytes_sent  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, bytes_sent=0, shift register=0, bit timer=0.
  - Applies immediately, including mid-frame; the partial frame is abandoned.
  - No FIFO pop is in flight after reset release.
- All outputs are registered.
- IDLE:
  - If enable=1 and fifo_empty=0 at a posedge, go to READ.
  - Otherwise stay in IDLE with tx=1.
- READ: fifo_rd_en=1 for exactly one cycle, then WAIT.
  - The FIFO advances its read pointer on the falling edge of read_en.
  - Its empty flag is therefore stale until two cycles after READ; the block never samples fifo_empty in that window.
- WAIT: one cycle. Capture fifo_data into the 8-bit shift register, then go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Eight bits, each held CLKS_PER_BIT cycles.
  - tx = shift[0]; shift right by one after each bit.
  - Bit index 0..7; after bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle, and bytes_sent increments on that same edge.
  - Then IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1; terminal count advances the bit or state. Reset to 0 on every state change.
- Timing, with cycle 0 = the IDLE cycle where the start condition is met:
  - fifo_rd_en high in cycle 1.
  - Capture in cycle 2.
  - tx falls at cycle 3.
  - Data bit i occupies cycles 3+CLKS_PER_BIT*(1+i) .. +CLKS_PER_BIT-1.
  - Stop bit ends at cycle 2+10*CLKS_PER_BIT.
  - Back-to-back frame period is 10*CLKS_PER_BIT+3 cycles.
- enable falling mid-frame: the current frame completes unchanged; no new READ is issued.
- enable rising while the FIFO is empty: remain in IDLE, no pulse on fifo_rd_en.
- fifo_empty changing during START/DATA/STOP is ignored. It is sampled only in IDLE.
- bytes_sent wraps from 2^CNT_W-1 to 0 without any other effect.
- Unreachable state encodings return to IDLE with tx=1.

Test Plan:
- Reset state: hold reset low, toggle the clock, pulse reset low again mid-frame -> tx=1, busy=0, fifo_rd_en=0, bytes_sent=0 immediately, without waiting for a clock edge.
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: FIFO holds 0xA5, enable=1.
  - fifo_rd_en is one pulse at cycle 1.
  - tx sequence in 4-cycle bits from cycle 3: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses at cycle 42; bytes_sent=1; busy low from cycle 43.
- Burst: FIFO preloaded with 0x01,0x80,0xFF (CLKS_PER_BIT=4) -> three frames with period 43 cycles, bytes in order, three rd_en pulses, bytes_sent=3, then IDLE with fifo_empty=1 and no extra pulse.
- Empty/enable gating:
  - enable=1 with the FIFO empty for 100 cycles -> no rd_en, tx=1.
  - Drop enable during DATA of byte 1 of 2 -> byte 1 completes, byte 2 is not read.
  - Raise enable again -> byte 2 is sent.
- Full FIFO drain: fill all 15 usable entries 0x00..0x0E -> exactly 15 frames with matching data; no read while fifo_empty=1.
- Wrap: preset bytes_sent near max via 2^CNT_W frames with CNT_W=4 -> count goes 15 -> 0.
